mux_nto1_stream: RTL and testbench

- Parametrised N-channel, W-bit-wide multiplexer with a registered output stage and a valid/ready output handshake.
- Successor to the team's fixed 5:1 single-bit mux.
- Two operating modes:
  - Direct: an external select picks the channel.
  - Scan: an internal sequencer round-robins through every channel, holding each one for a fixed number of transfers.
- Sits between a bank of sampled sources and a single downstream consumer, such as a serialiser or logger.

---
 rtl/mux_nto1_stream.sv | 151 +++++++++++++++
 tb/tb_mux_nto1_stream.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_stream.sv
// Purpose : N_CH x W-bit multiplexer with registered output; direct select or round-robin scan.
// Latency : 1 cycle from sel/in_data to out_data; one-cycle out_valid=0 bubble on every mode switch.
// Backpressure: out_valid && !out_ready freezes outputs, scan pointer, dwell count and state.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data [N_CH*W]    packed channels, channel k at [k*W +: W]
//   sel     [SEL_W]     channel select (direct mode only)
//   mode                0 = direct, 1 = scan
//   out_ready           consumer accepts the held sample
//   out_valid/out_data/out_ch/out_err   registered sample, its channel, out-of-range flag
//   out_par             (only with MUX_PARITY_EN) XOR reduction of out_data
//
// Optional feature macro: MUX_PARITY_EN

module mux_nto1_stream #(
  parameter int N_CH  = 5,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_CH*W-1:0]                           in_data,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  sel,
  input  logic                                        mode,
  input  logic                                        out_ready,
  output logic                                        out_valid,
  output logic [W-1:0]                                out_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  out_ch,
  output logic                                        out_err
`ifdef MUX_PARITY_EN
  ,
  output logic                                        out_par
`endif
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);
  localparam logic [7:0]       DCNT_LAST = 8'(DWELL - 1);

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [7:0]       r_dcnt;
  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_err;

  logic             w_stall;
  logic             w_mode_chg;
  logic             w_sel_ok;
  logic [W-1:0]     w_sel_dat;
  logic [W-1:0]     w_ptr_dat;
  logic [W-1:0]     w_nxt_dat;

  assign w_stall    = r_valid && !out_ready;
  assign w_mode_chg = (r_state == ST_DIRECT && mode) || (r_state == ST_SCAN && !mode);

  // Compare-based mux: an out-of-range sel never indexes past the bus and
  // falls through to 0 with w_sel_ok low.
  always_comb begin
    w_sel_ok  = 1'b0;
    w_sel_dat = '0;
    w_ptr_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_ok  = 1'b1;
        w_sel_dat = in_data[k*W +: W];
      end
      if (r_ptr == SEL_W'(k)) begin
        w_ptr_dat = in_data[k*W +: W];
      end
    end
  end

  assign w_nxt_dat = (r_state == ST_SCAN) ? w_ptr_dat : w_sel_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_dcnt  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= mode ? ST_SCAN : ST_DIRECT;
        end
        ST_DIRECT, ST_SCAN: begin
          if (!w_stall) begin
            if (w_mode_chg) begin
              // Switch costs one bubble; the old sample is not re-presented.
              r_state <= mode ? ST_SCAN : ST_DIRECT;
              r_valid <= 1'b0;
              if (mode) begin
                r_ptr  <= '0;
                r_dcnt <= '0;
              end
            end else if (r_state == ST_DIRECT) begin
              r_valid <= 1'b1;
              r_data  <= w_nxt_dat;
              r_ch    <= sel;
              r_err   <= !w_sel_ok;
            end else begin
              r_valid <= 1'b1;
              r_data  <= w_nxt_dat;
              r_ch    <= r_ptr;
              r_err   <= 1'b0;
              if (r_dcnt == DCNT_LAST) begin
                r_dcnt <= '0;
                r_ptr  <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
              end else begin
                r_dcnt <= r_dcnt + 8'd1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX_PARITY_EN
  logic r_par;

  // Loads under exactly the same condition as r_data so the two stay paired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if ((r_state == ST_DIRECT || r_state == ST_SCAN) && !w_stall && !w_mode_chg) begin
      r_par <= ^w_nxt_dat;
    end
  end

  assign out_par = r_par;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_err   = r_err;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Purpose : directed self-checking bench for mux_nto1_stream (N_CH=5, W=8, DWELL=2).
// Latency : samples DUT outputs 1 time unit after each rising edge.
// Backpressure: stalls driven through out_ready with hand-computed hold expectations.

module tb_mux_nto1_stream;

  localparam int N_CH  = 5;
  localparam int W     = 8;
  localparam int DWELL = 2;
  localparam int SEL_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] in_data;
  logic [SEL_W-1:0]  sel;
  logic              mode;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_err;
`ifdef MUX_PARITY_EN
  logic              out_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mux_nto1_stream #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_err   (out_err)
`ifdef MUX_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [2:0] c, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
    chk({tag, ".err"},   32'(out_err),   32'(e));
  endtask

  // Expected scan channel order with DWELL=2 and wrap after channel 4.
  int scan_ch [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};

  initial begin
    in_data   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    rst       = 1'b1;
    mode      = 1'b0;
    out_ready = 1'b1;
    sel       = 3'd3;

    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    // IDLE cycle: no capture yet.
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);

    tick();
    chk_out("direct3", 1'b1, 8'h13, 3'd3, 1'b0);

    sel = 3'd6;
    tick();
    chk_out("oor6", 1'b1, 8'h00, 3'd6, 1'b1);

    sel = 3'd0;
    tick();
    chk_out("direct0", 1'b1, 8'h10, 3'd0, 1'b0);

    // Switch to scan: bubble, then round-robin with a stall on the first ch=2 sample.
    mode = 1'b1;
    sel  = 3'd4;
    tick();
    chk("scan_bubble.valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      tick();
      chk_out($sformatf("scan[%0d]", i), 1'b1, 8'(8'h10 + scan_ch[i]), 3'(scan_ch[i]), 1'b0);
      if (i == 4) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk_out($sformatf("stall[%0d]", s), 1'b1, 8'h12, 3'd2, 1'b0);
        end
        out_ready = 1'b1;
      end
    end

    // Mode change requested while stalled is held off.
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 3'd1;
    tick();
    chk_out("defer0", 1'b1, 8'h10, 3'd0, 1'b0);
    tick();
    chk_out("defer1", 1'b1, 8'h10, 3'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("switch_bubble.valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("direct1", 1'b1, 8'h11, 3'd1, 1'b0);

    // Back into scan: pointer restarts at 0, then reset mid-scan.
    mode = 1'b1;
    tick();
    chk("rescan_bubble.valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("rescan0", 1'b1, 8'h10, 3'd0, 1'b0);
    tick();
    tick();
    chk_out("rescan2", 1'b1, 8'h11, 3'd1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

`ifdef MUX_PARITY_EN
    chk("par_rst", 32'(out_par), 32'd0);
    mode    = 1'b0;
    in_data = {8'h14, 8'h13, 8'h03, 8'h07, 8'h10};
    sel     = 3'd1;
    tick();
    tick();
    chk("par07.data", 32'(out_data), 32'h07);
    chk("par07.par",  32'(out_par),  32'd1);
    sel = 3'd2;
    tick();
    chk("par03.data", 32'(out_data), 32'h03);
    chk("par03.par",  32'(out_par),  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
